// File: rtl/coe_ec_fetch.sv
// Coefficient fetch for the entropy coder: walks a TU's 4x4 blocks, reads the coefficient RAM
// through the bank translator and streams the words out under valid/ready with a coded-block flag.
module coe_ec_fetch #(
    parameter int COE_WIDTH = 16,
    parameter int WORD_COE  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [1:0]                    sel_i,
    input  logic [3:0]                    tl_4x4_x_i,
    input  logic [3:0]                    tl_4x4_y_i,
    input  logic [1:0]                    size_i,
    output logic                          busy_o,
    output logic [1:0]                    ec_sel_o,
    output logic [8:0]                    ec_addr_o,
    input  logic [1:0]                    ec_bank_i,
    input  logic                          ec_cbank_i,
    output logic                          mem_rd_ena_o,
    output logic [8:0]                    mem_rd_addr_o,
    output logic [1:0]                    mem_rd_bank_o,
    output logic                          mem_rd_cbank_o,
    input  logic [WORD_COE*COE_WIDTH-1:0] mem_rd_dat_i,
    output logic                          coe_val_o,
    output logic [WORD_COE*COE_WIDTH-1:0] coe_dat_o,
    output logic                          coe_last_o,
    input  logic                          coe_rdy_i,
    output logic                          done_o,
    output logic                          cbf_o
);

    localparam int DW = WORD_COE * COE_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     sel_p0;
    logic [8:0]     addr_p0;
    logic [6:0]     cnt_p0;
    logic [6:0]     cnt_last;
    logic           vld_p1;
    logic           last_p1;
    logic [DW-1:0]  fifo_dat [2];
    logic [1:0]     fifo_last;
    logic           rd_ptr;
    logic           wr_ptr;
    logic [1:0]     occ;
    logic           cbf_acc;
    logic           cbf_r;
    logic           accept;
    logic           issue;
    logic           pop;
    logic           push;
    logic           final_issue;

    function automatic logic [7:0] interleave(input logic [3:0] x, input logic [3:0] y);
        return {x[3], y[3], x[2], y[2], x[1], y[1], x[0], y[0]};
    endfunction

    // Index of the final word: 2N-1 for N = 1/4/16/64 blocks.
    function automatic logic [6:0] last_word(input logic [1:0] size);
        case (size)
            2'd0:    return 7'd1;
            2'd1:    return 7'd7;
            2'd2:    return 7'd31;
            default: return 7'd127;
        endcase
    endfunction

    assign accept      = (state == IDLE) && start_i;
    assign coe_val_o   = (occ != 2'd0);
    assign pop         = coe_val_o && coe_rdy_i;
    assign push        = vld_p1;
    assign final_issue = (cnt_p0 == cnt_last);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = READ;
            end
            READ: begin
                // Credit: stored + returning words, less the one leaving, must leave a free slot.
                if (({1'b0, occ} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop})) begin
                    issue = 1'b1;
                    if (final_issue) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p1 && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // p0: address generation / read issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_p0    <= 2'd0;
            addr_p0   <= 9'd0;
            cnt_p0    <= 7'd0;
            cnt_last  <= 7'd0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            fifo_last <= 2'b00;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            cbf_acc   <= 1'b0;
            cbf_r     <= 1'b0;
        end else begin
            state   <= state_nxt;
            vld_p1  <= issue;
            last_p1 <= issue && final_issue;
            if (accept) begin
                sel_p0   <= sel_i;
                addr_p0  <= {1'b0, interleave(tl_4x4_x_i, tl_4x4_y_i)};
                cnt_p0   <= 7'd0;
                cnt_last <= last_word(size_i);
                cbf_acc  <= 1'b0;
            end else begin
                if (issue && !final_issue) begin
                    addr_p0 <= addr_p0[8] ? {1'b0, addr_p0[7:0] + 8'd1} : {1'b1, addr_p0[7:0]};
                    cnt_p0  <= cnt_p0 + 7'd1;
                end
                if (push) cbf_acc <= cbf_acc | (mem_rd_dat_i != '0);
            end
            // p1: returning RAM word enters the FIFO
            if (push) begin
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if ((state == DRAIN) && (state_nxt == DONE)) cbf_r <= cbf_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_dat[wr_ptr] <= mem_rd_dat_i;
    end

    assign busy_o         = (state != IDLE);
    assign ec_sel_o       = sel_p0;
    assign ec_addr_o      = addr_p0;
    assign mem_rd_ena_o   = issue;
    assign mem_rd_addr_o  = addr_p0;
    assign mem_rd_bank_o  = ec_bank_i;
    assign mem_rd_cbank_o = ec_cbank_i;
    assign coe_dat_o      = coe_val_o ? fifo_dat[rd_ptr] : '0;
    assign coe_last_o     = coe_val_o && fifo_last[rd_ptr];
    assign done_o         = (state == DONE);
    assign cbf_o          = cbf_r;

endmodule
